// File: rtl/merge2_4b_pkg.sv
// merge2_4b_pkg: shared width default and source encoding for the two-input merge stage
package merge2_4b_pkg;
    localparam int   NBITS_DEF = 4;
    localparam logic SRC_IN0   = 1'b0;
    localparam logic SRC_IN1   = 1'b1;
endpackage

// File: rtl/merge2_4b_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter; priority rotates only when a grant is consumed
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant,
    output logic       grant_idx
);
    logic r_prio;
    always_comb begin
        grant_idx = (req == 2'b11) ? r_prio : req[1];
        grant     = (req == 2'b00) ? 2'b00 : (grant_idx ? 2'b10 : 2'b01);
    end
    always_ff @(posedge clk) begin
        if (reset)
            r_prio <= 1'b0;
        else if (en)
            r_prio <= !grant_idx;
    end
endmodule

// File: rtl/merge2_4b.sv
// merge2_4b: round-robin merge of two valid/ready streams into a one-entry output register
module merge2_4b
    import merge2_4b_pkg::*;
#(
    parameter int NBITS = NBITS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_val,
    output logic             in0_rdy,
    input  logic [NBITS-1:0] in0_msg,
    input  logic             in1_val,
    output logic             in1_rdy,
    input  logic [NBITS-1:0] in1_msg,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [NBITS-1:0] out_msg,
    output logic             out_src
);
    logic             r_out_val;
    logic [NBITS-1:0] r_out_msg;
    logic             r_out_src;
    logic [1:0]       w_grant;
    logic             w_idx;
    logic             w_can_load;
    logic             w_xfer;
    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       ({in1_val, in0_val}),
        .en        (w_xfer),
        .grant     (w_grant),
        .grant_idx (w_idx)
    );
    // Draining and loading in the same edge keeps one word per cycle
    always_comb begin
        w_can_load = !r_out_val || out_rdy;
        in0_rdy    = !reset && w_can_load && w_grant[0];
        in1_rdy    = !reset && w_can_load && w_grant[1];
        w_xfer     = in0_rdy || in1_rdy;
        out_val    = r_out_val;
        out_msg    = r_out_msg;
        out_src    = r_out_src;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_val <= 1'b0;
            r_out_msg <= '0;
            r_out_src <= SRC_IN0;
        end else if (w_xfer) begin
            r_out_val <= 1'b1;
            r_out_msg <= w_idx ? in1_msg : in0_msg;
            r_out_src <= w_idx ? SRC_IN1 : SRC_IN0;
        end else if (out_rdy) begin
            r_out_val <= 1'b0;
        end
    end
endmodule
